// File: rtl/oh2b_pipe.sv
// One-hot to binary encoder with one output register and valid/ready handshake.
// Optional saturating error counter is enabled by defining OH2B_ERRCNT_EN.
module oh2b_pipe #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2**N-1:0]  positional,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     binary,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic             err_sticky,
    input  logic             clr_err,
    output logic [7:0]       err_cnt
);
    localparam int W = 2**N;

    logic [W-1:0] low_mask;
    logic [N-1:0] enc_bin;
    logic         enc_err;
    logic         xfer;

    logic [N-1:0] binary_reg;
    logic         err_reg;
    logic         valid_reg;
    logic         sticky_reg;

    // Isolate the lowest set bit; any other set bit makes the code invalid.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_low
            if (gi == 0) begin : g_first
                assign low_mask[gi] = positional[gi];
            end else begin : g_rest
                assign low_mask[gi] = positional[gi] & ~(|positional[gi-1:0]);
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < N; gi++) begin : g_enc
            logic [W-1:0] sel;
            always_comb begin
                sel = '0;
                for (int i = 0; i < W; i++) begin
                    sel[i] = ((i >> gi) & 1) == 1;
                end
            end
            assign enc_bin[gi] = |(low_mask & sel);
        end
    endgenerate

    assign enc_err  = (positional == '0) || (low_mask != positional);
    assign in_ready = !valid_reg || out_ready;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg  <= 1'b0;
            binary_reg <= '0;
            err_reg    <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            if (xfer) begin
                valid_reg  <= 1'b1;
                binary_reg <= enc_bin;
                err_reg    <= enc_err;
            end else if (out_ready) begin
                valid_reg  <= 1'b0;
            end
            // Clearing wins over a simultaneous erroneous transfer.
            if (clr_err) begin
                sticky_reg <= 1'b0;
            end else if (xfer && enc_err) begin
                sticky_reg <= 1'b1;
            end
        end
    end

`ifdef OH2B_ERRCNT_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_reg <= 8'd0;
        end else if (clr_err) begin
            err_cnt_reg <= 8'd0;
        end else if (xfer && enc_err && err_cnt_reg != 8'hFF) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`else
    assign err_cnt = 8'd0;
`endif

    assign binary     = binary_reg;
    assign err        = err_reg;
    assign out_valid  = valid_reg;
    assign err_sticky = sticky_reg;

endmodule
